trace_reader: RTL and testbench

- Read-side counterpart of the capture engine.
- After a capture completes (cap_done set, trace_end valid), it reads the full circular sample RAM oldest-to-newest and streams each byte to the UART transmit path over a valid/ready handshake.
- On completion it pulses clr_cap_done so the capture engine can re-arm.
- Sits between the capture RAM read port and the command/UART block.

---
 rtl/trace_reader_if.sv | 27 ++
 rtl/trace_reader.sv | 165 ++++++++++++++++
 tb/tb_trace_reader.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/trace_reader_if.sv
// trace_reader_if
//   Bundles the capture-RAM read port and the byte stream to the UART
//   transmitter used by trace_reader.
//   master : the reader side. It drives ram_en, ram_addr, tx_data and tx_valid,
//            and receives ram_rdata and tx_ready.
//   slave  : the RAM and transmitter side.
interface trace_reader_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
);
  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output ram_en, ram_addr, tx_data, tx_valid,
    input  ram_rdata, tx_ready
  );

  modport slave (
    input  ram_en, ram_addr, tx_data, tx_valid,
    output ram_rdata, tx_ready
  );
endinterface

// File: rtl/trace_reader.sv
// trace_reader
//   Dumps the circular capture RAM, from the oldest sample to the newest, to
//   the UART transmit path once a capture has completed. When the last byte is
//   accepted it pulses clr_cap_done so that the capture engine can re-arm.
//
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     dump_start_i    one-cycle dump request
//     cap_done_i      capture-complete flag
//     trace_end_i     next-write address at capture end (the oldest sample)
//     bus             trace_reader_if.master: RAM read port and tx valid/ready
//     busy_o          high in any state other than IDLE
//     dump_done_o     one-cycle pulse after the last byte is accepted
//     clr_cap_done_o  one-cycle pulse, coincident with dump_done_o
//     err_o           one-cycle pulse when a dump is requested without a capture
//
//   Define TRACE_READER_HDR_EN to prepend a 3-byte header to the dump:
//   0xA5, trace_end[ADDR_W-1:8], trace_end[7:0].
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for dump_start_i
//   HDR   | header byte in tx_data (built only with TRACE_READER_HDR_EN)
//   READ  | ram_en high, address = ptr
//   LATCH | RAM data returning; copied into tx_data
//   SEND  | tx_valid high, waiting for tx_ready
//   DONE  | dump_done / clr_cap_done pulse
module trace_reader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dump_start_i,
  input  logic              cap_done_i,
  input  logic [ADDR_W-1:0] trace_end_i,
  trace_reader_if.master    bus,
  output logic              busy_o,
  output logic              dump_done_o,
  output logic              clr_cap_done_o,
  output logic              err_o
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH - 1);

`ifdef TRACE_READER_HDR_EN
  typedef enum logic [2:0] {S_IDLE, S_READ, S_LATCH, S_SEND, S_DONE, S_HDR} state_t;
  logic [1:0]        hdr_idx_q;
`else
  typedef enum logic [2:0] {S_IDLE, S_READ, S_LATCH, S_SEND, S_DONE} state_t;
`endif

  state_t            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   cnt_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              tx_valid_q;
  logic              ram_en_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      ram_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef TRACE_READER_HDR_EN
      hdr_idx_q  <= '0;
`endif
    end else begin
      // ram_en, done and err are single-cycle strobes. Each one is set only
      // on the edge that enters the state in which it is asserted.
      ram_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (dump_start_i) begin
            if (cap_done_i) begin
              ptr_q   <= trace_end_i;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
`ifdef TRACE_READER_HDR_EN
              hdr_idx_q <= '0;
              state_q   <= S_HDR;
`else
              ram_en_q <= 1'b1;
              state_q  <= S_READ;
`endif
            end else begin
              err_q <= 1'b1;
            end
          end
        end
`ifdef TRACE_READER_HDR_EN
        // Each header byte spends one cycle loading and then waits for acceptance.
        S_HDR: begin
          if (!tx_valid_q) begin
            tx_valid_q <= 1'b1;
            case (hdr_idx_q)
              2'd0:    tx_data_q <= DATA_W'(8'hA5);
              2'd1:    tx_data_q <= DATA_W'(ptr_q >> 8);
              default: tx_data_q <= DATA_W'(ptr_q[7:0]);
            endcase
          end else if (bus.tx_ready) begin
            tx_valid_q <= 1'b0;
            hdr_idx_q  <= hdr_idx_q + 2'd1;
            if (hdr_idx_q == 2'd2) begin
              ram_en_q <= 1'b1;
              state_q  <= S_READ;
            end
          end
        end
`endif
        S_READ: state_q <= S_LATCH;
        S_LATCH: begin
          tx_data_q  <= bus.ram_rdata;
          tx_valid_q <= 1'b1;
          state_q    <= S_SEND;
        end
        S_SEND: begin
          if (bus.tx_ready) begin
            tx_valid_q <= 1'b0;
            ptr_q      <= ptr_q + ADDR_W'(1);
            cnt_q      <= cnt_q + (ADDR_W+1)'(1);
            if (cnt_q == CNT_LAST) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              ram_en_q <= 1'b1;
              state_q  <= S_READ;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q     <= 1'b0;
          tx_valid_q <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ram_en      = ram_en_q;
  assign bus.ram_addr    = ptr_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_valid    = tx_valid_q;
  assign busy_o          = busy_q;
  assign dump_done_o     = done_q;
  assign clr_cap_done_o  = done_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_trace_reader.sv
`timescale 1ns/1ps
module tb_trace_reader;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef TRACE_READER_HDR_EN
  localparam int HDR_N       = 3;
  localparam int HDR_EDGES   = 6;
  localparam int FIRST_EDGES = 2;
`else
  localparam int HDR_N       = 0;
  localparam int HDR_EDGES   = 0;
  localparam int FIRST_EDGES = 3;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              dump_start = 1'b0;
  logic              cap_done = 1'b0;
  logic [ADDR_W-1:0] trace_end = '0;
  logic              busy, dump_done, clr_cap_done, err;

  trace_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  trace_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dump_start_i   (dump_start),
    .cap_done_i     (cap_done),
    .trace_end_i    (trace_end),
    .bus            (bus),
    .busy_o         (busy),
    .dump_done_o    (dump_done),
    .clr_cap_done_o (clr_cap_done),
    .err_o          (err)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data is valid one cycle after ram_en.
  logic [7:0] mem [DEPTH];
  always @(posedge clk) if (bus.ram_en) bus.ram_rdata <= mem[bus.ram_addr];

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // The reference model lists the oldest-to-newest addresses starting at te.
  // A dump is then driven with chosen tx_ready behaviour while everything the
  // DUT emits is recorded.
  task automatic run_dump(input logic [ADDR_W-1:0] te, input int rdy_pct, input int bp_byte,
                          input bit poke, input int abort_at, input bit timing, input string name);
    logic [7:0]        exp_b[$];
    logic [ADDR_W-1:0] exp_a[$];
    logic [7:0]        got_b[$];
    logic [ADDR_W-1:0] got_a[$];
    logic [7:0]        prev_d;
    logic [ADDR_W-1:0] prev_a, ea, a;
    int n, acc, done_n, clr_n, coin_bad, err_n, stab_bad, ptr_bad, ovl_bad, done_at, first_v, hold, bad;
    bit prev_v, prev_rdy, prev_adv, finished;

    if (HDR_N > 0) begin
      exp_b.push_back(8'hA5);
      exp_b.push_back(8'(te >> 8));
      exp_b.push_back(te[7:0]);
    end
    for (int i = 0; i < DEPTH; i++) begin
      a = ADDR_W'((int'(te) + i) % DEPTH);
      exp_a.push_back(a);
      exp_b.push_back(mem[a]);
    end

    n = 0; acc = 0; done_n = 0; clr_n = 0; coin_bad = 0; err_n = 0; stab_bad = 0;
    ptr_bad = 0; ovl_bad = 0; done_at = -1; first_v = -1; hold = 5;
    prev_v = 0; prev_rdy = 0; prev_adv = 0; finished = 0; prev_d = '0; prev_a = '0;

    @(negedge clk);
    trace_end = te; cap_done = 1'b1; dump_start = 1'b1; bus.tx_ready = 1'b0;
    @(posedge clk);
    #1;
    dump_start = 1'b0;
    trace_end  = ADDR_W'($urandom);       // changes after the start must be ignored
    cap_done   = 1'($urandom_range(0, 1));

    while (!finished && n < 20000) begin
      @(negedge clk);
      if (abort_at >= 0 && acc >= abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        check({name, " async reset outputs"},
              32'({bus.tx_valid, bus.tx_data, bus.ram_en, bus.ram_addr, busy, dump_done, clr_cap_done, err}), 32'd0);
        bus.tx_ready = 1'b1;
        repeat (4) begin
          @(negedge clk);
          if (dump_done || clr_cap_done || busy) done_n++;
        end
        check({name, " no done or busy after abort"}, done_n + clr_n, 0);
        rst_n = 1'b1;
        return;
      end
      if (n == 0) check({name, " start addr"}, 32'(bus.ram_addr), 32'(te));
      else begin
        ea = prev_adv ? prev_a + ADDR_W'(1) : prev_a;
        if (bus.ram_addr !== ea) ptr_bad++;
      end
      if (bus.ram_en) got_a.push_back(bus.ram_addr);
      if (bus.ram_en && bus.tx_valid) ovl_bad++;
      if (prev_v && !prev_rdy && (!bus.tx_valid || bus.tx_data !== prev_d)) stab_bad++;
      if (bus.tx_valid && first_v < 0) first_v = n;
      if (err) err_n++;
      if (dump_done) begin done_n++; done_at = n; end
      if (clr_cap_done) clr_n++;
      if (dump_done !== clr_cap_done) coin_bad++;
      dump_start = poke && (n == 40);
      if (bus.tx_valid && acc == bp_byte && hold > 0) begin
        bus.tx_ready = 1'b0;
        hold--;
      end else begin
        bus.tx_ready = int'($urandom_range(0, 99)) < rdy_pct;
      end
      prev_adv = bus.tx_valid && bus.tx_ready && (acc >= HDR_N);
      if (bus.tx_valid && bus.tx_ready) begin
        got_b.push_back(bus.tx_data);
        acc++;
      end
      prev_v = bus.tx_valid; prev_rdy = bus.tx_ready; prev_d = bus.tx_data; prev_a = bus.ram_addr;
      if (dump_done) finished = 1;
      else begin
        @(posedge clk);
        n++;
      end
    end
    dump_start = 1'b0;

    check({name, " dump completed"}, 32'(finished), 32'd1);
    check({name, " byte count"}, got_b.size(), exp_b.size());
    bad = 0;
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) if (got_b[i] !== exp_b[i]) bad++;
    check({name, " byte mismatches"}, bad, 0);
    check({name, " first sample"}, 32'((got_b.size() > HDR_N) ? got_b[HDR_N] : 8'hxx), 32'(mem[te]));
    check({name, " last sample"}, 32'((got_b.size() > 0) ? got_b[got_b.size()-1] : 8'hxx),
          32'(mem[te - ADDR_W'(1)]));
    check({name, " ram_en pulses"}, got_a.size(), DEPTH);
    bad = 0;
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) if (got_a[i] !== exp_a[i]) bad++;
    check({name, " addr mismatches"}, bad, 0);
    check({name, " dump_done pulses"}, done_n, 1);
    check({name, " clr_cap_done pulses"}, clr_n, 1);
    check({name, " done/clr coincide"}, coin_bad, 0);
    check({name, " err pulses"}, err_n, 0);
    check({name, " tx held under backpressure"}, stab_bad, 0);
    check({name, " ptr advance only on accept"}, ptr_bad, 0);
    check({name, " ram_en during tx_valid"}, ovl_bad, 0);
    if (timing) begin
      check({name, " edges to first tx_valid"}, first_v + 1, FIRST_EDGES);
      check({name, " edges to dump_done"}, done_at + 1, 3 * DEPTH + 1 + HDR_EDGES);
    end
    @(negedge clk);
    check({name, " idle after done"}, 32'({busy, dump_done, clr_cap_done}), 32'd0);
  endtask

  initial begin
    bus.tx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
    #1;
    check("reset outputs", 32'({bus.tx_valid, bus.tx_data, bus.ram_en, bus.ram_addr, busy, dump_done, clr_cap_done, err}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Request without a capture: one-cycle err, never busy.
    @(negedge clk);
    cap_done = 1'b0; dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    check("err pulse", 32'({err, busy}), 32'b10);
    @(negedge clk);
    check("err one cycle", 32'({err, busy}), 32'b00);

    run_dump(9'h000, 100, -1, 0, -1, 1, "basic");
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
    run_dump(9'h1F0, 100, -1, 0, -1, 1, "wrap");
    run_dump(ADDR_W'($urandom), 100, 3, 0, -1, 0, "backpressure");
    run_dump(ADDR_W'($urandom), 60, -1, 1, -1, 0, "random_poke");
    run_dump(ADDR_W'($urandom), 70, -1, 0, 100, 0, "abort");
    run_dump(ADDR_W'($urandom), 100, -1, 0, -1, 1, "restart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
